m68k_bus_sync: RTL and testbench

//  68k-side bus front end between the raw FPGA bus pins and xosera_main.
//  - Synchronizes the asynchronous CS/RnW/address/data inputs into the pclk domain.
//  - Runs one bus-cycle FSM per chip-select assertion.
//  - Emits single-cycle read/write strobes with registered reg_num/bytesel/data.
//  - Drives 68k DTACK with a programmable wait, so registered read data is valid before DTACK.

---
 rtl/m68k_bus_sync.sv | 166 ++++++++++++++++
 tb/tb_m68k_bus_sync.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_sync.sv
// 68k bus front end: synchronizes raw bus pins into pclk, runs one bus-cycle FSM
// per chip-select assertion, emits single-cycle strobes and a wait-programmed DTACK.
module m68k_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_WAIT     = 2,
    parameter int unsigned WR_WAIT     = 1
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       bus_cs_n_i,
    input  logic       bus_rd_nwr_i,
    input  logic [3:0] bus_reg_num_i,
    input  logic       bus_bytesel_i,
    input  logic [7:0] bus_data_i,
    output logic       bus_dtack_o,
    output logic       write_strobe_o,
    output logic       read_strobe_o,
    output logic [3:0] reg_num_o,
    output logic       bytesel_o,
    output logic [7:0] bytedata_o
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned FILL_W = SYNC_STAGES + 1;

    typedef enum logic [1:0] {
        ST_RELEASE,
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   cs_prev;
    logic                   start_q;
    logic [FILL_W-1:0]      fill;

    logic       rd_q;
    logic [3:0] reg_q;
    logic       bsel_q;
    logic [7:0] data_q;

    logic       cs_act;
    logic       start_c;

    logic       dtack_nxt;
    logic       wr_nxt;
    logic       rd_nxt;
    logic [3:0] reg_nxt;
    logic       bsel_nxt;
    logic [7:0] data_nxt;

    assign cs_act  = ~cs_sync[SYNC_STAGES-1];
    assign start_c = cs_act & cs_prev;

    // Input synchronizers, chip-select edge detect, and post-reset fill tracker.
    // The fill tracker keeps RELEASE from trusting the reset-preset sync chain
    // until real pin samples have propagated all the way through it.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cs_sync <= '1;
            cs_prev <= 1'b1;
            start_q <= 1'b0;
            fill    <= '0;
            rd_q    <= 1'b0;
            reg_q   <= '0;
            bsel_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus_cs_n_i};
            cs_prev <= cs_sync[SYNC_STAGES-1];
            start_q <= start_c;
            fill    <= {fill[FILL_W-2:0], 1'b1};
            rd_q    <= bus_rd_nwr_i;
            reg_q   <= bus_reg_num_i;
            bsel_q  <= bus_bytesel_i;
            data_q  <= bus_data_i;
        end
    end

    // FSM state, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state          <= ST_RELEASE;
            cnt            <= '0;
            bus_dtack_o    <= 1'b0;
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;
            reg_num_o      <= '0;
            bytesel_o      <= 1'b0;
            bytedata_o     <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bus_dtack_o    <= dtack_nxt;
            write_strobe_o <= wr_nxt;
            read_strobe_o  <= rd_nxt;
            reg_num_o      <= reg_nxt;
            bytesel_o      <= bsel_nxt;
            bytedata_o     <= data_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dtack_nxt = 1'b0;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        reg_nxt   = reg_num_o;
        bsel_nxt  = bytesel_o;
        data_nxt  = bytedata_o;

        case (state)
            ST_RELEASE: begin
                if (fill[FILL_W-1] && !cs_act) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start_q) begin
                    state_nxt = ST_WAIT;
                    reg_nxt   = reg_q;
                    bsel_nxt  = bsel_q;
                    data_nxt  = data_q;
                    if (rd_q) begin
                        rd_nxt  = 1'b1;
                        cnt_nxt = CNT_W'(RD_WAIT);
                    end else begin
                        wr_nxt  = 1'b1;
                        cnt_nxt = CNT_W'(WR_WAIT);
                    end
                end
            end
            ST_WAIT: begin
                // An early CS release abandons the cycle without ever acknowledging it.
                if (!cs_act) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        dtack_nxt = 1'b1;
                        state_nxt = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (cs_act) begin
                    dtack_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_RELEASE;
            end
        endcase
    end

endmodule

// File: tb/tb_m68k_bus_sync.sv
// Scoreboard bench for m68k_bus_sync: stimulus pushes expected strobe/DTACK events
// with their cycle numbers; a negedge monitor pops and compares each observed event.
module tb_m68k_bus_sync;

    localparam int unsigned SYNC = 2;
    localparam int unsigned RDW  = 2;
    localparam int unsigned WRW  = 1;

    localparam int EV_WR   = 0;
    localparam int EV_RD   = 1;
    localparam int EV_RISE = 2;
    localparam int EV_FALL = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] reg_num;
        logic       bsel;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       cs_n;
    logic       rd_nwr;
    logic [3:0] reg_num;
    logic       bytesel;
    logic [7:0] data;
    logic       bus_dtack_o;
    logic       write_strobe_o;
    logic       read_strobe_o;
    logic [3:0] reg_num_o;
    logic       bytesel_o;
    logic [7:0] bytedata_o;

    ev_t  q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic dtack_prev = 1'b0;

    m68k_bus_sync #(
        .SYNC_STAGES(SYNC),
        .RD_WAIT    (RDW),
        .WR_WAIT    (WRW)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .bus_cs_n_i    (cs_n),
        .bus_rd_nwr_i  (rd_nwr),
        .bus_reg_num_i (reg_num),
        .bus_bytesel_i (bytesel),
        .bus_data_i    (data),
        .bus_dtack_o   (bus_dtack_o),
        .write_strobe_o(write_strobe_o),
        .read_strobe_o (read_strobe_o),
        .reg_num_o     (reg_num_o),
        .bytesel_o     (bytesel_o),
        .bytedata_o    (bytedata_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic push_ev(input int kind, input int c, input logic [3:0] r,
                           input logic b, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.reg_num = r; e.bsel = b; e.data = d;
        q.push_back(e);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        logic ok;
        n_vec++;
        if (q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_event: kind=%0d at cyc=%0d, required no event", kind, cyc);
        end else begin
            e  = q.pop_front();
            ok = (e.kind == kind) && (e.cyc == cyc);
            if (kind <= EV_RD)
                ok = ok && (reg_num_o == e.reg_num) && (bytesel_o == e.bsel) && (bytedata_o == e.data);
            if (!ok) begin
                n_miss++;
                $display("FAIL event: got kind=%0d cyc=%0d reg=%h bsel=%b data=%h, required kind=%0d cyc=%0d reg=%h bsel=%b data=%h",
                         kind, cyc, reg_num_o, bytesel_o, bytedata_o,
                         e.kind, e.cyc, e.reg_num, e.bsel, e.data);
            end
        end
    endtask

    // Monitor: every strobe and every DTACK edge must match the next queued expectation.
    always @(negedge clk) begin
        if (write_strobe_o && read_strobe_o) begin
            n_vec++;
            n_miss++;
            $display("FAIL both_strobes: got wr=1 rd=1, required at most one (cyc %0d)", cyc);
        end else if (write_strobe_o) begin
            check_ev(EV_WR);
        end else if (read_strobe_o) begin
            check_ev(EV_RD);
        end
        if (bus_dtack_o && !dtack_prev) check_ev(EV_RISE);
        if (!bus_dtack_o && dtack_prev) check_ev(EV_FALL);
        dtack_prev = bus_dtack_o;
    end

    // One bus cycle: CS released for gap clk, then held low for low clk.
    // Strobe lands SYNC+2 edges after the first low sample (edge e1 counts as 1);
    // DTACK happens only if CS is still seen low when the wait count expires.
    task automatic run_cycle(input int gap, input logic rd, input logic [3:0] rn,
                             input logic bs, input logic [7:0] d, input int low);
        int e1;
        int strobe;
        int w;
        repeat (gap) @(negedge clk);
        rd_nwr  = rd;
        reg_num = rn;
        bytesel = bs;
        data    = d;
        cs_n    = 1'b0;
        e1      = cyc + 1;
        strobe  = e1 + int'(SYNC) + 1;
        w       = rd ? int'(RDW) : int'(WRW);
        push_ev(rd ? EV_RD : EV_WR, strobe, rn, bs, d);
        if (low > w + 1) begin
            push_ev(EV_RISE, strobe + w, '0, 1'b0, '0);
            push_ev(EV_FALL, e1 + low + int'(SYNC), '0, 1'b0, '0);
        end
        repeat (low) @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_dtack"}, int'(bus_dtack_o), 0);
        check_val({tag, "_reg"},   int'(reg_num_o),   0);
        check_val({tag, "_bsel"},  int'(bytesel_o),   0);
        check_val({tag, "_data"},  int'(bytedata_o),  0);
    endtask

    initial begin
        int e1;
        reset_i = 1'b1;
        cs_n    = 1'b1;
        rd_nwr  = 1'b1;
        reg_num = '0;
        bytesel = 1'b0;
        data    = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        check_val("reset_wstrobe", int'(write_strobe_o), 0);
        check_val("reset_rstrobe", int'(read_strobe_o),  0);
        reset_i = 1'b0;

        // Plain write, CS held long.
        run_cycle(5, 1'b0, 4'h3, 1'b1, 8'hA5, 12);
        data    = 8'hFF;
        reg_num = 4'h9;
        bytesel = 1'b0;
        repeat (3) @(negedge clk);
        check_val("hold_reg",  int'(reg_num_o),  'h3);
        check_val("hold_bsel", int'(bytesel_o),  1);
        check_val("hold_data", int'(bytedata_o), 'hA5);

        // Read, CS held long.
        run_cycle(3, 1'b1, 4'hF, 1'b0, 8'h5C, 12);

        // Aborted read, then a normal write.
        run_cycle(3, 1'b1, 4'h7, 1'b1, 8'h66, 3);
        run_cycle(3, 1'b0, 4'h1, 1'b0, 8'h81, 6);

        // Back-to-back writes with CS high 2 clk between.
        run_cycle(3, 1'b0, 4'h2, 1'b0, 8'h12, 8);
        run_cycle(2, 1'b0, 4'h2, 1'b1, 8'h34, 8);

        // Inputs change one clk before CS falls: the new values must be latched.
        repeat (3) @(negedge clk);
        rd_nwr  = 1'b1;
        reg_num = 4'hA;
        bytesel = 1'b0;
        data    = 8'h11;
        repeat (2) @(negedge clk);
        rd_nwr  = 1'b0;
        reg_num = 4'h5;
        bytesel = 1'b1;
        data    = 8'hC3;
        run_cycle(1, 1'b0, 4'h5, 1'b1, 8'hC3, 6);

        // Reset while acknowledged with CS still low.
        repeat (3) @(negedge clk);
        rd_nwr  = 1'b0;
        reg_num = 4'h8;
        bytesel = 1'b0;
        data    = 8'h7E;
        cs_n    = 1'b0;
        e1      = cyc + 1;
        push_ev(EV_WR, e1 + int'(SYNC) + 1, 4'h8, 1'b0, 8'h7E);
        push_ev(EV_RISE, e1 + int'(SYNC) + 1 + int'(WRW), '0, 1'b0, '0);
        repeat (8) @(negedge clk);
        push_ev(EV_FALL, cyc + 1, '0, 1'b0, '0);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_zero_outputs("midack_reset");
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        run_cycle(2, 1'b0, 4'h4, 1'b0, 8'h9D, 6);

        repeat (20) @(negedge clk);
        check_val("pending_events", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
